// File: rtl/pixel_sequencer.sv
// Acquisition/readout sequencer for the pixel control block: store window, reset
// pulses per event, then the memory-pointer clear/advance handshake for readout.
module pixel_sequencer #(
  parameter int INTEG_LEN = 75,
  parameter int NUM_MEM   = 4,
  parameter int SET_LEN   = 5,
  parameter int SET_GAP   = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       trg_mode_i,
  input  logic       trg_det_i,
  input  logic [3:0] cfg_num_evt_i,
  input  logic       pix_reset_busy_i,
  input  logic       last_mem_i,
  output logic       pix_reset_o,
  output logic       pix_store_o,
  output logic       evt_num_end_o,
  output logic       mem_set_clr_o,
  output logic       mem_set_en_o,
  output logic [3:0] read_mem_o,
  output logic [3:0] evt_cnt_o,
  output logic       busy_o,
  output logic       seq_done_o
);
  localparam int CMAX = (INTEG_LEN > SET_GAP) ? ((INTEG_LEN > SET_LEN) ? INTEG_LEN : SET_LEN)
                                              : ((SET_GAP > SET_LEN) ? SET_GAP : SET_LEN);
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_RST_PULSE, S_INTEG, S_FINAL,
    S_CLR_HI, S_CLR_GAP, S_SET_HI, S_SET_GAP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    evt_q, evt_d, tgt_q, tgt_d, rep_q, rep_d;
  logic          mode_q, mode_d;
  logic          pix_reset_q, pix_reset_d, pix_store_q, pix_store_d;
  logic          evt_end_q, evt_end_d, clr_q, clr_d, en_q, en_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [3:0]    read_mem_q, read_mem_d;
  logic          rst_emitted, win_end;

  // A reset pulse (plain or final) is issued in the cycle after the state decides
  // to emit it; pix_reset_q high in that state means the pulse is already out.
  assign rst_emitted = pix_reset_q;
  assign win_end     = (cnt_q == CW'(INTEG_LEN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = evt_q;
    tgt_d   = tgt_q;
    rep_d   = rep_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: if (start_i && !stop_i) begin
        state_d = S_ARM;
        evt_d   = '0;
        mode_d  = trg_mode_i;
        if (cfg_num_evt_i == 4'd0)                tgt_d = 4'd1;
        else if (cfg_num_evt_i > 4'(NUM_MEM))     tgt_d = 4'(NUM_MEM);
        else                                      tgt_d = cfg_num_evt_i;
      end
      S_ARM: state_d = stop_i ? S_FINAL : S_RST_PULSE;
      S_RST_PULSE: begin
        if (stop_i) state_d = S_FINAL;
        else if (rst_emitted) begin
          state_d = S_INTEG;
          cnt_d   = '0;
        end
      end
      S_INTEG: begin
        if (stop_i) state_d = S_FINAL;
        else if (mode_q ? trg_det_i : win_end) begin
          evt_d   = evt_q + 4'd1;
          state_d = (evt_q + 4'd1 == tgt_q) ? S_FINAL : S_RST_PULSE;
        end else if (win_end) state_d = S_RST_PULSE;
        else cnt_d = cnt_q + CW'(1);
      end
      S_FINAL: if (rst_emitted) begin
        state_d = (evt_q == 4'd0) ? S_DONE : S_CLR_HI;
        cnt_d   = '0;
        rep_d   = '0;
      end
      S_CLR_HI: begin
        if (cnt_q == CW'(SET_LEN - 1)) begin
          state_d = S_CLR_GAP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_CLR_GAP, S_SET_GAP: begin
        if (cnt_q == CW'(SET_GAP - 1)) begin
          cnt_d = '0;
          if (state_q == S_SET_GAP && (last_mem_i || rep_q == evt_q)) state_d = S_DONE;
          else begin
            state_d = S_SET_HI;
            rep_d   = rep_q + 4'd1;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      S_SET_HI: begin
        if (cnt_q == CW'(SET_LEN - 1)) begin
          state_d = S_SET_GAP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register with the state change.
  always_comb begin
    pix_reset_d = ((state_d == S_RST_PULSE) || (state_d == S_FINAL)) && !pix_reset_busy_i
                  && !(state_q == state_d && rst_emitted);
    evt_end_d   = pix_reset_d && (state_d == S_FINAL);
    pix_store_d = (state_d == S_ARM) || (state_d == S_RST_PULSE) ||
                  (state_d == S_INTEG) || (state_d == S_FINAL);
    clr_d       = (state_d == S_CLR_HI);
    en_d        = (state_d == S_SET_HI);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    read_mem_d  = (state_d >= S_CLR_HI) ? evt_d : 4'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      evt_q       <= '0;
      tgt_q       <= 4'd1;
      rep_q       <= '0;
      mode_q      <= 1'b0;
      pix_reset_q <= 1'b0;
      pix_store_q <= 1'b0;
      evt_end_q   <= 1'b0;
      clr_q       <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      read_mem_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evt_q       <= evt_d;
      tgt_q       <= tgt_d;
      rep_q       <= rep_d;
      mode_q      <= mode_d;
      pix_reset_q <= pix_reset_d;
      pix_store_q <= pix_store_d;
      evt_end_q   <= evt_end_d;
      clr_q       <= clr_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      read_mem_q  <= read_mem_d;
    end
  end

  assign pix_reset_o   = pix_reset_q;
  assign pix_store_o   = pix_store_q;
  assign evt_num_end_o = evt_end_q;
  assign mem_set_clr_o = clr_q;
  assign mem_set_en_o  = en_q;
  assign read_mem_o    = read_mem_q;
  assign evt_cnt_o     = evt_q;
  assign busy_o        = busy_q;
  assign seq_done_o    = done_q;
endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer: cycle-numbered scenarios with hand-derived event timing.
module tb_pixel_sequencer;
  logic       clk_i = 1'b0, rst_i = 1'b1;
  logic       start_i = 0, stop_i = 0, trg_mode_i = 0, trg_det_i = 0;
  logic [3:0] cfg_num_evt_i = 0;
  logic       pix_reset_busy_i = 0, last_mem_i = 0;
  logic       pix_reset_o, pix_store_o, evt_num_end_o, mem_set_clr_o, mem_set_en_o;
  logic [3:0] read_mem_o, evt_cnt_o;
  logic       busy_o, seq_done_o;

  pixel_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .trg_mode_i(trg_mode_i), .trg_det_i(trg_det_i), .cfg_num_evt_i(cfg_num_evt_i),
    .pix_reset_busy_i(pix_reset_busy_i), .last_mem_i(last_mem_i),
    .pix_reset_o(pix_reset_o), .pix_store_o(pix_store_o), .evt_num_end_o(evt_num_end_o),
    .mem_set_clr_o(mem_set_clr_o), .mem_set_en_o(mem_set_en_o), .read_mem_o(read_mem_o),
    .evt_cnt_o(evt_cnt_o), .busy_o(busy_o), .seq_done_o(seq_done_o)
  );

  always #20 clk_i = ~clk_i;

  int nchk = 0, npass = 0;
  int rst_q[$], end_q[$], en_q[$], trg_q[$];
  int store_first, store_last, clr_first, clr_last, en_n, done_c, done_n, dbl;
  int rdm_clr, rdm_done, rdm_bad, snap, busy_any, evt_last, busy_last;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int qat(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  // Cycle c is the clock period ending at edge c; START is sampled at edge 0.
  task automatic run(input int mode, input int cfg, input int stop_c, input int busy_c,
                     input int busy_n, input int lm_a, input int lm_b, input int rst_c,
                     input int max_c);
    logic prev_rst, prev_en, hit;
    rst_q.delete(); end_q.delete(); en_q.delete();
    store_first = -1; store_last = -1; clr_first = -1; clr_last = -1; en_n = 0;
    done_c = -1; done_n = 0; dbl = 0; rdm_clr = -1; rdm_done = -1; rdm_bad = 0;
    snap = -1; busy_any = 0; prev_rst = 0; prev_en = 0;
    @(negedge clk_i);
    start_i = 1; trg_mode_i = mode[0]; cfg_num_evt_i = cfg[3:0]; stop_i = (stop_c == 0);
    @(posedge clk_i);
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk_i);
      start_i = 0;
      if (pix_reset_o) begin rst_q.push_back(c); if (prev_rst) dbl++; end
      if (pix_store_o) begin if (store_first < 0) store_first = c; store_last = c; end
      if (pix_store_o && read_mem_o != 0) rdm_bad++;
      if (evt_num_end_o) end_q.push_back(c);
      if (mem_set_clr_o) begin if (clr_first < 0) clr_first = c; clr_last = c; rdm_clr = read_mem_o; end
      if (mem_set_en_o) begin en_n++; if (!prev_en) en_q.push_back(c); end
      if (seq_done_o) begin done_c = c; done_n++; rdm_done = read_mem_o; end
      if (busy_o) busy_any = 1;
      if (c == rst_c + 1)
        snap = {pix_reset_o, pix_store_o, evt_num_end_o, mem_set_clr_o, mem_set_en_o,
                read_mem_o, evt_cnt_o, busy_o, seq_done_o};
      prev_rst = pix_reset_o; prev_en = mem_set_en_o;
      evt_last = evt_cnt_o; busy_last = busy_o;
      hit = 0;
      foreach (trg_q[i]) if (trg_q[i] == c) hit = 1;
      trg_det_i = hit;
      stop_i = (c == stop_c);
      pix_reset_busy_i = (c >= busy_c) && (c < busy_c + busy_n);
      last_mem_i = (c >= lm_a) && (c <= lm_b);
      rst_i = (c == rst_c);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    trg_det_i = 0; stop_i = 0; pix_reset_busy_i = 0; last_mem_i = 0; rst_i = 0;
    trg_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs", {pix_reset_o, pix_store_o, evt_num_end_o, mem_set_clr_o, mem_set_en_o,
                          read_mem_o, evt_cnt_o, busy_o, seq_done_o}, 0);
    rst_i = 0;

    // free-run, 2 events
    run(0, 2, -1, -1, 0, -1, -1, -1, 210);
    chk("fr_store_first", store_first, 1);
    chk("fr_store_last", store_last, 154);
    chk("fr_nrst", rst_q.size(), 3);
    chk("fr_rst0", qat(rst_q, 0), 2);
    chk("fr_rst1", qat(rst_q, 1), 78);
    chk("fr_rst2", qat(rst_q, 2), 154);
    chk("fr_end", qat(end_q, 0), 154);
    chk("fr_nend", end_q.size(), 1);
    chk("fr_clr_first", clr_first, 155);
    chk("fr_clr_last", clr_last, 159);
    chk("fr_en0", qat(en_q, 0), 170);
    chk("fr_en1", qat(en_q, 1), 185);
    chk("fr_en_cycles", en_n, 10);
    chk("fr_read_mem", rdm_clr, 2);
    chk("fr_read_mem_done", rdm_done, 2);
    chk("fr_read_mem_acq", rdm_bad, 0);
    chk("fr_done", done_c, 200);
    chk("fr_done_n", done_n, 1);
    chk("fr_evt_hold", evt_last, 2);
    chk("fr_idle", busy_last, 0);

    // trigger mode, 3 events, one timed-out window
    trg_q = '{20, 40, 127};
    run(1, 3, -1, -1, 0, -1, -1, -1, 200);
    chk("tm_nrst", rst_q.size(), 5);
    chk("tm_rst1", qat(rst_q, 1), 21);
    chk("tm_rst2", qat(rst_q, 2), 41);
    chk("tm_rst_timeout", qat(rst_q, 3), 117);
    chk("tm_final", qat(rst_q, 4), 128);
    chk("tm_end", qat(end_q, 0), 128);
    chk("tm_evt", evt_last, 3);
    chk("tm_done", done_c, 189);

    // STOP at cycle 100 of a 4-event free run
    run(0, 4, 100, -1, 0, -1, -1, -1, 140);
    chk("stp_final", qat(end_q, 0), 101);
    chk("stp_nrst", rst_q.size(), 3);
    chk("stp_read_mem", rdm_clr, 1);
    chk("stp_nen", en_q.size(), 1);
    chk("stp_done", done_c, 132);

    // STOP in first INTEG: no readout
    run(0, 4, 30, -1, 0, -1, -1, -1, 45);
    chk("stp0_final", qat(end_q, 0), 31);
    chk("stp0_evt", evt_last, 0);
    chk("stp0_noclr", clr_first, -1);
    chk("stp0_done", done_c, 32);

    // busy over the final reset; CFG 0 means one event
    run(0, 0, -1, 77, 7, -1, -1, -1, 125);
    chk("bsy_nrst", rst_q.size(), 2);
    chk("bsy_delayed", qat(rst_q, 1), 85);
    chk("bsy_width", dbl, 0);
    chk("bsy_end", qat(end_q, 0), 85);
    chk("bsy_store_last", store_last, 85);
    chk("bsy_evt", evt_last, 1);
    chk("bsy_done", done_c, 116);

    // CFG 9 clamps to 4
    run(0, 9, -1, -1, 0, -1, -1, -1, 390);
    chk("clamp_nrst", rst_q.size(), 5);
    chk("clamp_evt", evt_last, 4);
    chk("clamp_read_mem", rdm_clr, 4);
    chk("clamp_nen", en_q.size(), 4);
    chk("clamp_done", done_c, 382);

    // LAST_MEM in 2nd SET_GAP ends readout
    run(0, 4, -1, -1, 0, 342, 351, -1, 370);
    chk("lm_nen", en_q.size(), 2);
    chk("lm_done", done_c, 352);

    // RST mid-INTEG
    run(0, 2, -1, -1, 0, -1, -1, 50, 70);
    chk("rsti_outputs", snap, 0);
    chk("rsti_nrst", rst_q.size(), 1);
    chk("rsti_nodone", done_n, 0);
    chk("rsti_idle", busy_last, 0);

    // RST mid-SET_HI
    run(0, 1, -1, -1, 0, -1, -1, 96, 130);
    chk("rsts_en0", qat(en_q, 0), 94);
    chk("rsts_outputs", snap, 0);
    chk("rsts_nodone", done_n, 0);
    chk("rsts_idle", busy_last, 0);

    // START with STOP stays idle
    run(0, 2, 0, -1, 0, -1, -1, -1, 10);
    chk("ss_busy", busy_any, 0);
    chk("ss_nrst", rst_q.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
